// File: rtl/sum_display_pkg.sv
// Shared definitions for the sum_display block: FSM states, step count, segment patterns.
// Latency: n/a (types, constants and one pure function only).
// Backpressure: n/a.
package sum_display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int SHIFT_STEPS = 8;

    // Active-low segment patterns, bit order g..a
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    // One double-dabble step on the {bcd[11:0], bin[7:0]} working register:
    // every BCD nibble >= 5 gets +3 independently (no inter-nibble carry),
    // then the whole register shifts left by one.
    function automatic logic [19:0] dabble_step(input logic [19:0] w);
        logic [19:0] a;
        a = w;
        for (int i = 0; i < 3; i++) begin
            if (a[8 + 4*i +: 4] >= 4'd5) begin
                a[8 + 4*i +: 4] = a[8 + 4*i +: 4] + 4'd3;
            end
        end
        return {a[18:0], 1'b0};
    endfunction

endpackage

// File: rtl/sum_display_if.sv
// Bundle of the request/result signals between the accumulator side and sum_display.
// Latency: n/a (wires only).
// Backpressure: none; busy tells the requester that load is currently ignored.
//   load/bin             : capture request and the 8-bit value to convert
//   busy/done            : conversion running / one-cycle new-result pulse
//   hundreds/tens/ones   : registered BCD digits
//   seg2/seg1/seg0       : active-low 7-segment outputs (g..a) for those digits
interface sum_display_if;
    import sum_display_pkg::*;

    logic       load;
    logic [7:0] bin;
    logic       busy;
    logic       done;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
    logic [6:0] seg2;
    logic [6:0] seg1;
    logic [6:0] seg0;

    modport master (
        output load, bin,
        input  busy, done, hundreds, tens, ones, seg2, seg1, seg0
    );

    modport slave (
        input  load, bin,
        output busy, done, hundreds, tens, ones, seg2, seg1, seg0
    );

endinterface

// File: rtl/sum_display_bcd_to_7seg.sv
// Decodes one BCD digit to an active-low 7-segment pattern (g..a), with forced blank.
// Latency: combinational.
// Backpressure: none.
//   bcd   : 4-bit digit; codes 10-15 decode to blank
//   blank : forces all segments off
//   seg   : active-low segments
module bcd_to_7seg
    import sum_display_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (bcd)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/sum_display.sv
// Captures an 8-bit sum, converts it to 3 BCD digits by sequential double-dabble, drives 7-seg.
// Latency: load at edge k -> digits and segments update at edge k+8, done high k+8..k+9.
// Backpressure: load is only honoured in IDLE; requests during SHIFT/DONE are dropped.
//   clk, rst : clock, asynchronous active-high reset
//   dsp      : sum_display_if.slave (load/bin in; busy/done/digits/segments out)
// Build option LEADING_ZERO_BLANK_EN blanks leading zero digits (ones always shown).
module sum_display
    import sum_display_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    sum_display_if.slave   dsp
);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [19:0] work;
    logic [19:0] work_step;
    logic        last_step;
    logic [3:0]  hundreds;
    logic [3:0]  tens;
    logic [3:0]  ones;
    logic        blank2;
    logic        blank1;

    assign work_step = dabble_step(work);
    assign last_step = (state == SHIFT) && (cnt == 4'(SHIFT_STEPS - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and status outputs
    always_comb begin
        state_nxt = state;
        dsp.busy  = 1'b0;
        dsp.done  = 1'b0;
        case (state)
            IDLE: begin
                if (dsp.load) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                dsp.busy = 1'b1;
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                dsp.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Double-dabble datapath and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= 4'd0;
            work     <= 20'd0;
            hundreds <= 4'd0;
            tens     <= 4'd0;
            ones     <= 4'd0;
        end else begin
            if (state == IDLE && dsp.load) begin
                work <= {12'd0, dsp.bin};
                cnt  <= 4'd0;
            end else if (state == SHIFT) begin
                work <= work_step;
                cnt  <= cnt + 4'd1;
                // Publish the post-shift BCD of the final step so the digits
                // only ever change to a complete result.
                if (last_step) begin
                    hundreds <= work_step[19:16];
                    tens     <= work_step[15:12];
                    ones     <= work_step[11:8];
                end
            end
        end
    end

    assign dsp.hundreds = hundreds;
    assign dsp.tens     = tens;
    assign dsp.ones     = ones;

`ifdef LEADING_ZERO_BLANK_EN
    assign blank2 = (hundreds == 4'd0);
    assign blank1 = (hundreds == 4'd0) && (tens == 4'd0);
`else
    assign blank2 = 1'b0;
    assign blank1 = 1'b0;
`endif

    bcd_to_7seg u_seg2 (.bcd(hundreds), .blank(blank2), .seg(dsp.seg2));
    bcd_to_7seg u_seg1 (.bcd(tens),     .blank(blank1), .seg(dsp.seg1));
    bcd_to_7seg u_seg0 (.bcd(ones),     .blank(1'b0),   .seg(dsp.seg0));

endmodule

// File: tb/tb_sum_display.sv
// Directed bench for sum_display: reset, latency/handshake, extremes, dropped loads,
// mid-conversion reset and a full 0..255 back-to-back sweep.
// Define LEADING_ZERO_BLANK_EN to check the leading-zero blanking build.
module tb_sum_display;

    localparam logic [6:0] S_BL = 7'b1111111;
    localparam logic [6:0] S_0  = 7'b1000000;
    localparam logic [6:0] S_1  = 7'b1111001;
    localparam logic [6:0] S_2  = 7'b0100100;
    localparam logic [6:0] S_4  = 7'b0011001;
    localparam logic [6:0] S_5  = 7'b0010010;
    localparam logic [6:0] S_7  = 7'b1111000;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    sum_display_if dif();

    sum_display dut (
        .clk (clk),
        .rst (rst),
        .dsp (dif)
    );

    function automatic logic [6:0] seg_exp(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse load for one edge; bin is scrambled right after capture.
    task automatic start(input logic [7:0] v);
        dif.bin  = v;
        dif.load = 1'b1;
        tick();
        dif.load = 1'b0;
        dif.bin  = v ^ 8'hA5;
    endtask

    // Returns number of ticks until done is seen, or -1 after 20 ticks.
    task automatic wait_done(output int n);
        n = -1;
        for (int i = 0; i < 20; i++) begin
            if (dif.done === 1'b1) begin
                n = i;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        logic [20:0] exp_seg;
`ifdef LEADING_ZERO_BLANK_EN
        exp_seg = {S_BL, S_BL, S_0};
`else
        exp_seg = {S_0, S_0, S_0};
`endif
        rst      = 1'b1;
        dif.load = 1'b0;
        dif.bin  = 8'd0;
        tick();
        tick();
        checks++;
        if ({dif.busy, dif.done} !== 2'b00) begin
            failures++;
            $display("FAIL reset_status busy/done=%b required=00", {dif.busy, dif.done});
        end
        checks++;
        if ({dif.hundreds, dif.tens, dif.ones} !== 12'h000) begin
            failures++;
            $display("FAIL reset_digits got=%h required=000", {dif.hundreds, dif.tens, dif.ones});
        end
        checks++;
        if ({dif.seg2, dif.seg1, dif.seg0} !== exp_seg) begin
            failures++;
            $display("FAIL reset_segs got=%b required=%b", {dif.seg2, dif.seg1, dif.seg0}, exp_seg);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_convert_120();
        bit busy_bad = 0;
        start(8'd120);
        for (int i = 0; i < 8; i++) begin
            if (dif.busy !== 1'b1 || dif.done !== 1'b0) busy_bad = 1;
            if (i == 7) begin
                checks++;
                if ({dif.hundreds, dif.tens, dif.ones} !== 12'h000) begin
                    failures++;
                    $display("FAIL c120_no_partial got=%h required=000",
                             {dif.hundreds, dif.tens, dif.ones});
                end
            end
            tick();
        end
        checks++;
        if (busy_bad) begin
            failures++;
            $display("FAIL c120_busy_window busy not high for 8 cycles with done low");
        end
        checks++;
        if ({dif.busy, dif.done} !== 2'b01) begin
            failures++;
            $display("FAIL c120_done busy/done=%b required=01", {dif.busy, dif.done});
        end
        checks++;
        if ({dif.hundreds, dif.tens, dif.ones} !== 12'h120) begin
            failures++;
            $display("FAIL c120_digits got=%h required=120", {dif.hundreds, dif.tens, dif.ones});
        end
        checks++;
        if ({dif.seg2, dif.seg1, dif.seg0} !== {S_1, S_2, S_0}) begin
            failures++;
            $display("FAIL c120_segs got=%b required=%b",
                     {dif.seg2, dif.seg1, dif.seg0}, {S_1, S_2, S_0});
        end
        tick();
        checks++;
        if ({dif.busy, dif.done} !== 2'b00) begin
            failures++;
            $display("FAIL c120_done_single busy/done=%b required=00", {dif.busy, dif.done});
        end
    endtask

    task automatic test_extremes();
        int n;
        logic [20:0] exp0;
`ifdef LEADING_ZERO_BLANK_EN
        exp0 = {S_BL, S_BL, S_0};
`else
        exp0 = {S_0, S_0, S_0};
`endif
        start(8'd255);
        wait_done(n);
        checks++;
        if (n != 8) begin
            failures++;
            $display("FAIL c255_latency got=%0d required=8", n);
        end
        checks++;
        if ({dif.hundreds, dif.tens, dif.ones, dif.seg2, dif.seg1, dif.seg0} !==
            {12'h255, S_2, S_5, S_5}) begin
            failures++;
            $display("FAIL c255_result got=%h/%b required=255/%b",
                     {dif.hundreds, dif.tens, dif.ones}, {dif.seg2, dif.seg1, dif.seg0},
                     {S_2, S_5, S_5});
        end
        tick();
        start(8'd0);
        wait_done(n);
        checks++;
        if (n != 8 || {dif.hundreds, dif.tens, dif.ones} !== 12'h000) begin
            failures++;
            $display("FAIL c0_digits got=%h n=%0d required=000 n=8",
                     {dif.hundreds, dif.tens, dif.ones}, n);
        end
        checks++;
        if ({dif.seg2, dif.seg1, dif.seg0} !== exp0) begin
            failures++;
            $display("FAIL c0_segs got=%b required=%b", {dif.seg2, dif.seg1, dif.seg0}, exp0);
        end
        tick();
    endtask

    task automatic test_seven();
        int n;
        logic [20:0] exp7;
`ifdef LEADING_ZERO_BLANK_EN
        exp7 = {S_BL, S_BL, S_7};
`else
        exp7 = {S_0, S_0, S_7};
`endif
        start(8'd7);
        wait_done(n);
        checks++;
        if (n != 8 || {dif.hundreds, dif.tens, dif.ones} !== 12'h007) begin
            failures++;
            $display("FAIL c7_digits got=%h n=%0d required=007 n=8",
                     {dif.hundreds, dif.tens, dif.ones}, n);
        end
        checks++;
        if ({dif.seg2, dif.seg1, dif.seg0} !== exp7) begin
            failures++;
            $display("FAIL c7_segs got=%b required=%b", {dif.seg2, dif.seg1, dif.seg0}, exp7);
        end
        tick();
    endtask

    task automatic test_ignored_load();
        int dones = 0;
        start(8'd45);
        tick();
        tick();
        tick();
        dif.bin  = 8'd99;
        dif.load = 1'b1;
        tick();
        dif.load = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (dif.done === 1'b1) dones++;
            tick();
        end
        checks++;
        if (dones != 1) begin
            failures++;
            $display("FAIL ignored_load_done_count got=%0d required=1", dones);
        end
        checks++;
        if ({dif.hundreds, dif.tens, dif.ones, dif.seg1, dif.seg0} !== {12'h045, S_4, S_5}) begin
            failures++;
            $display("FAIL ignored_load_hold got=%h required=045", {dif.hundreds, dif.tens, dif.ones});
        end
    endtask

    task automatic test_reset_mid_shift();
        int dones = 0;
        int n;
        logic [20:0] exp_seg;
`ifdef LEADING_ZERO_BLANK_EN
        exp_seg = {S_BL, S_BL, S_0};
`else
        exp_seg = {S_0, S_0, S_0};
`endif
        start(8'd200);
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if ({dif.busy, dif.done, dif.hundreds, dif.tens, dif.ones} !== 14'd0) begin
            failures++;
            $display("FAIL midrst_clear busy=%b done=%b digits=%h required 0/0/000",
                     dif.busy, dif.done, {dif.hundreds, dif.tens, dif.ones});
        end
        checks++;
        if ({dif.seg2, dif.seg1, dif.seg0} !== exp_seg) begin
            failures++;
            $display("FAIL midrst_segs got=%b required=%b", {dif.seg2, dif.seg1, dif.seg0}, exp_seg);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (dif.done === 1'b1 || dif.busy === 1'b1) dones++;
            tick();
        end
        checks++;
        if (dones != 0) begin
            failures++;
            $display("FAIL midrst_no_done active_cycles=%0d required=0", dones);
        end
        start(8'd200);
        wait_done(n);
        checks++;
        if (n != 8 || {dif.hundreds, dif.tens, dif.ones, dif.seg2, dif.seg1, dif.seg0} !==
            {12'h200, S_2, S_0, S_0}) begin
            failures++;
            $display("FAIL midrst_reload got=%h n=%0d required=200 n=8",
                     {dif.hundreds, dif.tens, dif.ones}, n);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int n;
        int h, t, o;
        logic [6:0] s2, s1;
        for (int v = 0; v < 256; v++) begin
            h = v / 100;
            t = (v / 10) % 10;
            o = v % 10;
            s2 = seg_exp(h);
            s1 = seg_exp(t);
`ifdef LEADING_ZERO_BLANK_EN
            if (h == 0) s2 = S_BL;
            if (h == 0 && t == 0) s1 = S_BL;
`endif
            start(8'(v));
            wait_done(n);
            checks++;
            if (n != 8 || {dif.hundreds, dif.tens, dif.ones} !== {4'(h), 4'(t), 4'(o)}) begin
                failures++;
                $display("FAIL sweep_digits bin=%0d got=%h n=%0d required=%0d%0d%0d n=8",
                         v, {dif.hundreds, dif.tens, dif.ones}, n, h, t, o);
            end
            checks++;
            if ({dif.seg2, dif.seg1, dif.seg0} !== {s2, s1, seg_exp(o)}) begin
                failures++;
                $display("FAIL sweep_segs bin=%0d got=%b required=%b",
                         v, {dif.seg2, dif.seg1, dif.seg0}, {s2, s1, seg_exp(o)});
            end
            tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        dif.load = 1'b0;
        dif.bin  = 8'd0;
        test_reset();
        test_convert_120();
        test_extremes();
        test_seven();
        test_ignored_load();
        test_reset_mid_shift();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
